// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  // Instruction class produced by the decoder; illegal covers bad R-type functs too.
  typedef enum logic [2:0] {
    IC_RTYPE   = 3'd0,
    IC_MEM     = 3'd1,
    IC_BEQ     = 3'd2,
    IC_ADDI    = 3'd3,
    IC_JUMP    = 3'd4,
    IC_ILLEGAL = 3'd5
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mips_decode.sv
// Combinational opcode/funct legality check and R-type funct to ALU operation map.
module mips_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] iclass,
  output logic [2:0] funct_alu
);

  logic funct_legal;

  always_comb begin
    funct_alu   = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    iclass = IC_ILLEGAL;
    case (opcode)
      OP_RTYPE:     iclass = funct_legal ? IC_RTYPE : IC_ILLEGAL;
      OP_LW, OP_SW: iclass = IC_MEM;
      OP_BEQ:       iclass = IC_BEQ;
      OP_ADDI:      iclass = IC_ADDI;
      OP_J:         iclass = IC_JUMP;
      default:      iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: sequences instructions through the classic
// FSM, counts memory wait cycles and traps on illegal encodings or timeouts.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic       pc_en,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_source,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [2:0]       iclass_raw;
  logic [2:0]       funct_alu;
  iclass_t          iclass;
  logic             mem_stall;

  mips_decode u_decode (
    .opcode    (opcode),
    .funct     (funct),
    .iclass    (iclass_raw),
    .funct_alu (funct_alu)
  );

  assign iclass = iclass_t'(iclass_raw);
  assign mem_stall = (state_q == S_FETCH || state_q == S_MEM_READ || state_q == S_MEM_WRITE)
                     && !mem_ready;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (iclass)
          IC_RTYPE: state_d = S_EXECUTE;
          IC_MEM:   state_d = S_MEM_ADDR;
          IC_BEQ:   state_d = S_BRANCH;
          IC_ADDI:  state_d = S_ADDI_EXEC;
          IC_JUMP:  state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
    // A stall on the last permitted cycle overrides the normal hold.
    if (TIMEOUT_EN && mem_stall && wait_cnt_q == CNT_LAST) begin
      state_d = S_TRAP;
      cause_d = CAUSE_TIMEOUT;
    end
    if (state_d != state_q) wait_cnt_d = '0;
    else if (mem_stall)     wait_cnt_d = wait_cnt_q + CNT_W'(1);
    else                    wait_cnt_d = wait_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    pc_en      = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_ctrl   = ALU_AND;
    pc_source  = PCSRC_ALU;
    retire     = 1'b0;
    trap       = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_ctrl  = ALU_ADD;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          alu_ctrl  = ALU_ADD;
        end
        S_MEM_ADDR, S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_ctrl  = ALU_ADD;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          retire    = mem_ready;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_ctrl  = funct_alu;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_SUB;
          pc_source = PCSRC_ALUOUT;
          pc_en     = alu_zero;
          retire    = 1'b1;
        end
        S_JUMP: begin
          pc_en     = 1'b1;
          pc_source = PCSRC_JUMP;
          retire    = 1'b1;
        end
        S_ADDI_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign state      = reset ? 4'd0 : state_q;
  assign trap_cause = reset ? CAUSE_NONE : cause_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 16, max cycles to wait for mem_ready before trapping; 0 disables the timeout.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: opcode  input  6  instr[31:26]; funct  input  6  instr[5:0]; alu_zero  input  1  ALU result == 0; mem_ready  input  1  memory access completes this cycle.
REQ-005 SHALL have outputs, 1 bit each: mem_read, mem_write, i_or_d (1 = data address), ir_write, reg_write, reg_dst (1 = rd), mem_to_reg, alu_src_a (1 = rs, 0 = PC), pc_en.
REQ-006 SHALL have outputs: alu_src_b  2  (00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2); alu_ctrl  3; pc_source  2  (00 ALU, 01 ALUOut, 10 jump target).
REQ-007 SHALL have outputs: retire  1  one-cycle pulse per completed instruction; trap  1  sticky fault; trap_cause  2  (00 none, 01 illegal, 10 timeout); state  4  current state.

Function
REQ-008 SHALL sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB and TRAP.
REQ-009 SHALL decode control outputs combinationally from state, plus mem_ready and alu_zero where stated; outputs not listed for a state SHALL be 0.
REQ-010 SHALL encode alu_ctrl as 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-011 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD; ir_write and pc_en SHALL equal mem_ready; it SHALL stay in FETCH until mem_ready, then go to DECODE.
REQ-012 DECODE SHALL drive alu_src_a=0, alu_src_b=11, ADD, and then go to: R-type (000000) -> EXECUTE; lw (100011) or sw (101011) -> MEM_ADDR; beq (000100) -> BRANCH; addi (001000) -> ADDI_EXEC; j (000010) -> JUMP; any other opcode -> TRAP with cause 01.
REQ-013 An R-type funct outside add 100000, sub 100010, and 100100, or 100101, slt 101010 SHALL go from DECODE to TRAP with cause 01.
REQ-014 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, ADD, then go to MEM_READ for lw or MEM_WRITE for sw.
REQ-015 MEM_READ SHALL drive mem_read=1, i_or_d=1, waiting for mem_ready, then go to MEM_WB.
REQ-016 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-017 MEM_WRITE SHALL drive mem_write=1, i_or_d=1, waiting for mem_ready, then go to FETCH.
REQ-018 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00, alu_ctrl from funct; ALU_WB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-019 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_en=alu_zero.
REQ-020 JUMP SHALL drive pc_en=1, pc_source=10.
REQ-021 ADDI_EXEC SHALL drive alu_src_a=1, alu_src_b=10, ADD; ADDI_WB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-022 MEM_WB, ALU_WB, ADDI_WB, BRANCH and JUMP SHALL go to FETCH after one cycle.
REQ-023 retire SHALL be asserted in MEM_WB, ALU_WB, ADDI_WB, BRANCH and JUMP, and in MEM_WRITE when mem_ready=1.
REQ-024 Latency with mem_ready high on first request SHALL be: lw 5 cycles; R-type, sw and addi 4 cycles; beq and j 3 cycles.
REQ-025 A wait counter SHALL increment each cycle in FETCH, MEM_READ or MEM_WRITE with mem_ready=0, and SHALL clear on any state change.
REQ-026 When TIMEOUT_CYCLES>0, counter == TIMEOUT_CYCLES-1 and mem_ready=0, the next state SHALL be TRAP with cause 10.
REQ-027 mem_ready in that same cycle SHALL win over the timeout.
REQ-028 TRAP SHALL drive all control outputs 0 and trap=1, and SHALL hold until reset.
REQ-029 trap_cause SHALL latch on entry to TRAP.
REQ-030 mem_ready outside FETCH, MEM_READ or MEM_WRITE SHALL be ignored.

Reset
REQ-031 While reset=1, all outputs SHALL be 0 (including trap, trap_cause and retire), and the state, counter and cause SHALL load FETCH, 0 and 00 on the clock edge.
REQ-032 Reset asserted mid-instruction, including during a memory wait or TRAP, SHALL abandon it, and the first cycle after release SHALL be FETCH.

Structure
REQ-033 A shared package SHALL hold the state encodings, opcode and funct constants, alu_ctrl codes, and alu_src_b/pc_source encodings.
REQ-034 The opcode/funct legality and alu_ctrl mapping SHALL be a combinational sub-module mips_decode instantiated once.

Verification
REQ-035 Test: add (funct 100000), mem_ready constantly 1 -> state FETCH, DECODE, EXECUTE, ALU_WB; alu_ctrl=010 in EXECUTE; reg_write=1, reg_dst=1 in ALU_WB; one retire pulse.
REQ-036 Test: lw, mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, then MEM_WB with mem_to_reg=1; total 8 cycles.
REQ-037 Test: beq with alu_zero=1, then with alu_zero=0 -> pc_en=1 then 0 in BRANCH, pc_source=01, retire both times.
REQ-038 Test: opcode 111111 -> TRAP after DECODE, trap_cause=01; FETCH after reset.
REQ-039 Test: TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH -> TRAP on 5th cycle, cause 10; repeat with mem_ready=1 on 4th cycle -> DECODE, no trap.
REQ-040 Test: reset pulsed during MEM_WRITE wait -> mem_write=0 during reset; FETCH next; no retire.
